// File: rtl/multicycle_alu_if.sv
// Handshake and data bundle between the control FSM (master) and
// multicycle_alu (slave). Operands and opcode travel towards the ALU;
// Busy/Done and the registered results travel back.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [2:0]       ALUControl;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] ALUResultHi;
  logic             Zero;
  logic             DivByZero;

  modport master (
    output Start, SrcA, SrcB, ALUControl,
    input  Busy, Done, ALUResult, ALUResultHi, Zero, DivByZero
  );

  modport slave (
    input  Start, SrcA, SrcB, ALUControl,
    output Busy, Done, ALUResult, ALUResultHi, Zero, DivByZero
  );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu: registered ALU with Start/Busy/Done handshake.
// Single-cycle ops (add, sub, and, xor, or, slt) finish one cycle after an
// accepted Start. With MULTICYCLE_ALU_MULDIV_EN defined, MUL (shift-add) and
// DIVU (restoring) iterate for WIDTH cycles in CALC; without it they complete
// in one cycle with an all-zero result and no CALC state exists.
// Results hold their value until the next operation completes.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  multicycle_alu_if.slave bus
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

`ifdef MULTICYCLE_ALU_MULDIV_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIN  = 2'd2
  } state_t;
`endif

  state_t           state_reg;
  state_t           state_next;
  logic             accept;

  logic             slt_bit;
  logic [WIDTH-1:0] alu_value;

  // Write-back request: which values land in the result registers this edge
  logic             wr_en;
  logic [WIDTH-1:0] wr_lo;
  logic [WIDTH-1:0] wr_hi;
  logic             wr_dbz;

  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_hi_reg;
  logic             zero_reg;
  logic             dbz_reg;

  assign slt_bit = $signed(bus.SrcA) < $signed(bus.SrcB);

  // Single-cycle result; mul/divu slots yield 0 here (iterative path handles them)
  always_comb begin
    alu_value = '0;
    case (bus.ALUControl)
      OP_ADD:  alu_value = bus.SrcA + bus.SrcB;
      OP_SUB:  alu_value = bus.SrcA - bus.SrcB;
      OP_AND:  alu_value = bus.SrcA & bus.SrcB;
      OP_XOR:  alu_value = bus.SrcA ^ bus.SrcB;
      OP_OR:   alu_value = bus.SrcA | bus.SrcB;
      OP_SLT:  alu_value = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_MUL:  alu_value = '0;
      OP_DIVU: alu_value = '0;
    endcase
  end

`ifdef MULTICYCLE_ALU_MULDIV_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  // Shared iteration datapath: work_hi/work_lo hold {partial product,
  // multiplier} for MUL and {remainder, dividend/quotient} for DIVU.
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] work_hi_reg;
  logic [WIDTH-1:0] work_lo_reg;
  logic [WIDTH-1:0] opnd_reg;
  logic             is_div_reg;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;

  logic             is_iter;
  logic             div_zero;
  logic             last_iter;

  assign is_iter   = (bus.ALUControl[2:1] == 2'b11);
  assign div_zero  = (bus.ALUControl == OP_DIVU) && (bus.SrcB == '0);
  assign last_iter = (count_reg == CNT_W'(1));

  // One shift-add (MUL) or restoring shift-subtract (DIVU) step
  always_comb begin
    iter_hi   = work_hi_reg;
    iter_lo   = work_lo_reg;
    mul_sum   = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {work_hi_reg, work_lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    if (is_div_reg) begin
      // A set top bit means the trial subtraction borrowed: restore
      if (div_diff[WIDTH]) begin
        iter_hi = div_shift[WIDTH-1:0];
        iter_lo = {work_lo_reg[WIDTH-2:0], 1'b0};
      end else begin
        iter_hi = div_diff[WIDTH-1:0];
        iter_lo = {work_lo_reg[WIDTH-2:0], 1'b1};
      end
    end else begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], work_lo_reg[WIDTH-1:1]};
    end
  end

  // Capture operands on accept (SrcA/SrcB are free to change afterwards),
  // then advance one iteration per CALC cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg   <= '0;
      work_hi_reg <= '0;
      work_lo_reg <= '0;
      opnd_reg    <= '0;
      is_div_reg  <= 1'b0;
    end else if (state_reg == CALC) begin
      count_reg   <= count_reg - CNT_W'(1);
      work_hi_reg <= iter_hi;
      work_lo_reg <= iter_lo;
    end else if (accept) begin
      count_reg   <= CNT_W'(WIDTH);
      is_div_reg  <= bus.ALUControl[0];
      work_hi_reg <= '0;
      // MUL: multiplier shifts through work_lo, multiplicand in opnd.
      // DIVU: dividend shifts out of work_lo, divisor in opnd.
      work_lo_reg <= bus.ALUControl[0] ? bus.SrcA : bus.SrcB;
      opnd_reg    <= bus.ALUControl[0] ? bus.SrcB : bus.SrcA;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: Start is taken in IDLE or FIN, ignored while iterating
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE, FIN: begin
        if (bus.Start) begin
          accept = 1'b1;
`ifdef MULTICYCLE_ALU_MULDIV_EN
          state_next = (is_iter && !div_zero) ? CALC : FIN;
`else
          state_next = FIN;
`endif
        end else begin
          state_next = IDLE;
        end
      end
`ifdef MULTICYCLE_ALU_MULDIV_EN
      CALC: begin
        if (last_iter) begin
          state_next = FIN;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Select what gets written into the result registers on this edge
  always_comb begin
    wr_en  = 1'b0;
    wr_lo  = alu_value;
    wr_hi  = '0;
    wr_dbz = 1'b0;
    if (accept) begin
      wr_en = 1'b1;
`ifdef MULTICYCLE_ALU_MULDIV_EN
      if (div_zero) begin
        // Divide by zero short-circuits CALC with a fixed result
        wr_lo  = '1;
        wr_hi  = bus.SrcA;
        wr_dbz = 1'b1;
      end else if (is_iter) begin
        // Results stay put until the iteration finishes
        wr_en = 1'b0;
      end
`endif
    end
`ifdef MULTICYCLE_ALU_MULDIV_EN
    if ((state_reg == CALC) && last_iter) begin
      wr_en = 1'b1;
      wr_lo = iter_lo;
      wr_hi = iter_hi;
    end
`endif
  end

  // Result registers; Zero is derived from the value being written
  always_ff @(posedge clk) begin
    if (reset) begin
      result_reg    <= '0;
      result_hi_reg <= '0;
      zero_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
    end else if (wr_en) begin
      result_reg    <= wr_lo;
      result_hi_reg <= wr_hi;
      zero_reg      <= (wr_lo == '0);
      dbz_reg       <= wr_dbz;
    end
  end

  assign bus.Done        = (state_reg == FIN);
`ifdef MULTICYCLE_ALU_MULDIV_EN
  assign bus.Busy        = (state_reg == CALC);
`else
  assign bus.Busy        = 1'b0;
`endif
  assign bus.ALUResult   = result_reg;
  assign bus.ALUResultHi = result_hi_reg;
  assign bus.Zero        = zero_reg;
  assign bus.DivByZero   = dbz_reg;

endmodule

// File: tb/tb_multicycle_alu.sv
// Testbench for multicycle_alu. A behavioural model (plain arithmetic plus a
// pending-result countdown) predicts every output on every cycle; directed
// tests pin the model to hand-computed values, then random traffic runs.
// Follows MULTICYCLE_ALU_MULDIV_EN the same way the design does.
module tb_multicycle_alu;
  localparam int W = 32;

`ifdef MULTICYCLE_ALU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(W)) bus ();
  multicycle_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  // Model state
  int           busy_left = 0;
  logic         exp_done  = 1'b0;
  logic [W-1:0] exp_lo    = '0;
  logic [W-1:0] exp_hi    = '0;
  logic         exp_zero  = 1'b0;
  logic         exp_dbz   = 1'b0;
  logic [W-1:0] pend_lo, pend_hi;

  task automatic chk_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // What an op must produce, straight from the arithmetic definitions
  task automatic model_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] lo, output logic [W-1:0] hi, output logic dbz);
    logic [2*W-1:0] prod;
    lo  = '0;
    hi  = '0;
    dbz = 1'b0;
    case (op)
      3'd0: lo = a + b;
      3'd1: lo = a - b;
      3'd2: lo = a & b;
      3'd3: lo = a ^ b;
      3'd4: lo = a | b;
      3'd5: lo = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      3'd6: if (MULDIV) begin
              prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
              lo = prod[W-1:0];
              hi = prod[2*W-1:W];
            end
      3'd7: if (MULDIV) begin
              if (b == '0) begin
                lo  = '1;
                hi  = a;
                dbz = 1'b1;
              end else begin
                lo = a / b;
                hi = a % b;
              end
            end
    endcase
  endtask

  // Model update at each rising edge
  initial begin
    logic [W-1:0] r_lo, r_hi;
    logic         r_dbz;
    forever begin
      @(posedge clk);
      if (reset) begin
        busy_left = 0;
        exp_done  = 1'b0;
        exp_lo    = '0;
        exp_hi    = '0;
        exp_zero  = 1'b0;
        exp_dbz   = 1'b0;
      end else begin
        exp_done = 1'b0;
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) begin
            exp_lo   = pend_lo;
            exp_hi   = pend_hi;
            exp_zero = (pend_lo == '0);
            exp_dbz  = 1'b0;
            exp_done = 1'b1;
          end
        end else if (bus.Start) begin
          model_op(bus.ALUControl, bus.SrcA, bus.SrcB, r_lo, r_hi, r_dbz);
          if (MULDIV && bus.ALUControl[2:1] == 2'b11 && !r_dbz) begin
            busy_left = W;
            pend_lo   = r_lo;
            pend_hi   = r_hi;
          end else begin
            exp_lo   = r_lo;
            exp_hi   = r_hi;
            exp_zero = (r_lo == '0);
            exp_dbz  = r_dbz;
            exp_done = 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk_bit("busy", bus.Busy, busy_left > 0);
        chk_bit("done", bus.Done, exp_done);
        chk_word("result", bus.ALUResult, exp_lo);
        chk_word("result_hi", bus.ALUResultHi, exp_hi);
        chk_bit("zero", bus.Zero, exp_zero);
        chk_bit("divbyzero", bus.DivByZero, exp_dbz);
      end
    end
  end

  // Issue one op at the current falling edge and wait (bounded) for Done
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_n);
    bus.ALUControl = op;
    bus.SrcA       = a;
    bus.SrcB       = b;
    bus.Start      = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    lat       = 1;
    busy_n    = 0;
    while (!bus.Done && lat < 100) begin
      if (bus.Busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (!bus.Done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no Done after %0d cycles expected Done", lat);
    end
    $display("op %0d a=%h b=%h -> lat %0d res %h hi %h z %b dbz %b",
             op, a, b, lat, bus.ALUResult, bus.ALUResultHi, bus.Zero, bus.DivByZero);
  endtask

  initial begin
    int lat, busy_n, done_seen;
    logic [W-1:0] a, b;

    reset          = 1'b1;
    bus.Start      = 1'b0;
    bus.SrcA       = '0;
    bus.SrcB       = '0;
    bus.ALUControl = 3'd0;
    repeat (2) @(negedge clk);
    armed = 1'b1;

    // Reset state
    chk_bit("rst_busy", bus.Busy, 1'b0);
    chk_bit("rst_done", bus.Done, 1'b0);
    chk_word("rst_result", bus.ALUResult, 32'h0);
    chk_word("rst_hi", bus.ALUResultHi, 32'h0);
    chk_bit("rst_zero", bus.Zero, 1'b0);
    chk_bit("rst_dbz", bus.DivByZero, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // 1: add
    do_op(3'd0, 32'd5, 32'd7, lat, busy_n);
    chk_int("t1_lat", lat, 1);
    chk_word("t1_res", bus.ALUResult, 32'd12);
    chk_word("t1_model", exp_lo, 32'd12);
    chk_bit("t1_zero", bus.Zero, 1'b0);
    chk_word("t1_hi", bus.ALUResultHi, 32'h0);

    // 2: sub to zero, then signed slt (back-to-back, issued in FIN)
    do_op(3'd1, 32'h1234, 32'h1234, lat, busy_n);
    chk_word("t2_sub", bus.ALUResult, 32'h0);
    chk_bit("t2_zero", bus.Zero, 1'b1);
    do_op(3'd5, 32'hFFFF_FFFF, 32'd1, lat, busy_n);
    chk_int("t2_slt_lat", lat, 1);
    chk_word("t2_slt", bus.ALUResult, 32'd1);
    do_op(3'd5, 32'd1, 32'hFFFF_FFFF, lat, busy_n);
    chk_word("t2_slt_rev", bus.ALUResult, 32'd0);

    // 3: mul
    @(negedge clk);
    do_op(3'd6, 32'hFFFF_FFFF, 32'd2, lat, busy_n);
    if (MULDIV) begin
      chk_int("t3_lat", lat, 33);
      chk_int("t3_busy", busy_n, 32);
      chk_word("t3_lo", bus.ALUResult, 32'hFFFF_FFFE);
      chk_word("t3_hi", bus.ALUResultHi, 32'd1);
      chk_word("t3_model_hi", exp_hi, 32'd1);
    end else begin
      chk_int("t3_lat", lat, 1);
      chk_word("t3_lo", bus.ALUResult, 32'h0);
      chk_bit("t3_zero", bus.Zero, 1'b1);
    end

    // 4: divu, then divide by zero, then an add clears DivByZero
    do_op(3'd7, 32'd100, 32'd7, lat, busy_n);
    chk_int("t4_lat", lat, MULDIV ? 33 : 1);
    chk_word("t4_q", bus.ALUResult, MULDIV ? 32'd14 : 32'd0);
    chk_word("t4_r", bus.ALUResultHi, MULDIV ? 32'd2 : 32'd0);
    do_op(3'd7, 32'd9, 32'd0, lat, busy_n);
    chk_int("t4_dz_lat", lat, 1);
    chk_word("t4_dz_q", bus.ALUResult, MULDIV ? 32'hFFFF_FFFF : 32'h0);
    chk_word("t4_dz_r", bus.ALUResultHi, MULDIV ? 32'd9 : 32'h0);
    chk_bit("t4_dz_flag", bus.DivByZero, MULDIV);
    chk_bit("t4_dz_zero", bus.Zero, !MULDIV);
    do_op(3'd4, 32'h00F0, 32'h0F00, lat, busy_n);
    chk_bit("t4_dz_clear", bus.DivByZero, 1'b0);
    chk_word("t4_or", bus.ALUResult, 32'h0FF0);

    // 5: Start pulsed during CALC is ignored
    if (MULDIV) begin
      bus.ALUControl = 3'd6;
      bus.SrcA       = 32'd3;
      bus.SrcB       = 32'd5;
      bus.Start      = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      repeat (4) @(negedge clk);
      bus.ALUControl = 3'd0;
      bus.SrcA       = 32'd100;
      bus.SrcB       = 32'd200;
      bus.Start      = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      lat = 0;
      while (!bus.Done && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      chk_word("t5_ignored", bus.ALUResult, 32'd15);
    end
    do_op(3'd3, 32'hFF00, 32'h0FF0, lat, busy_n);
    do_op(3'd2, 32'hFF00, 32'h0FF0, lat, busy_n);
    chk_int("t5_b2b_lat", lat, 1);
    chk_word("t5_b2b_and", bus.ALUResult, 32'h0F00);

    // 6: reset in the middle of an op
    do_op(3'd0, 32'd1, 32'd1, lat, busy_n);
    bus.ALUControl = 3'd6;
    bus.SrcA       = 32'd1000;
    bus.SrcB       = 32'd1000;
    bus.Start      = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_bit("t6_busy", bus.Busy, 1'b0);
    chk_bit("t6_done", bus.Done, 1'b0);
    chk_word("t6_res", bus.ALUResult, 32'h0);
    reset     = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done) done_seen++;
    end
    chk_int("t6_no_done", done_seen, 0);

    // Random traffic; Start is offered freely, including while busy
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 999) == 0);
      bus.Start = ($urandom_range(0, 2) != 0);
      bus.ALUControl = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = a;
        2:       b = W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      bus.SrcA = a;
      bus.SrcB = b;
      @(negedge clk);
    end
    bus.Start = 1'b0;
    reset     = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
